alu_sequencer: RTL and testbench

Command-driven initiator for the combinational 8-bit signed ALU. It accepts operation commands over a valid/ready handshake and drives registered operands and opcode to one external ALU instance. It samples the ALU's result and overflow one cycle later and returns them through a small result FIFO with its own valid/ready handshake. It also supports chaining, where the previous result replaces operand A, and keeps a saturating overflow count.

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_result_fifo.sv | 56 +++++
 rtl/alu_sequencer.sv | 121 ++++++++++++
 tb/tb_alu_sequencer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, result-word layout and FSM encoding for the ALU sequencer
package alu_pkg;

  localparam int NIO = 8;
  localparam int NOP = 3;

  localparam logic [NOP-1:0] OP_ADD = 3'd0;
  localparam logic [NOP-1:0] OP_SUB = 3'd1;
  localparam logic [NOP-1:0] OP_MAX = 3'd2;
  localparam logic [NOP-1:0] OP_MIN = 3'd3;
  localparam logic [NOP-1:0] OP_SHL = 3'd4;
  localparam logic [NOP-1:0] OP_SHR = 3'd5;

  // Result word: {err, ov, z}
  localparam int RES_W   = NIO + 2;
  localparam int Z_LSB   = 0;
  localparam int OV_BIT  = NIO;
  localparam int ERR_BIT = NIO + 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_t;

  // Opcodes above OP_SHR are illegal and produce an err result.
  function automatic logic op_is_legal(input logic [NOP-1:0] op);
    return op <= OP_SHR;
  endfunction

endpackage

// File: rtl/alu_result_fifo.sv
// rtl/alu_result_fifo.sv - synchronous result FIFO with registered storage and occupancy count
module alu_result_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic                     valid,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  // A pop on an empty FIFO and a push on a full one are both dropped.
  assign do_pop  = pop && (count_q != '0);
  assign do_push = push && (count_q != CW'(DEPTH));

  // Pointer and occupancy bookkeeping; push+pop together leaves count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array; no reset needed because the head is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push && !rst) mem[wr_ptr] <= push_data;
  end

  assign valid = (count_q != '0);
  assign head  = valid ? mem[rd_ptr] : '0;
  assign count = count_q;

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - command-driven initiator for an external 8-bit signed ALU
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int nIO   = NIO,
  parameter int nOP   = NOP,
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [nOP-1:0] cmd_op,
  input  logic [nIO-1:0] cmd_a,
  input  logic [nIO-1:0] cmd_b,
  input  logic           cmd_chain,
  output logic [nIO-1:0] alu_a,
  output logic [nIO-1:0] alu_b,
  output logic [nOP-1:0] alu_op,
  input  logic [nIO-1:0] alu_z,
  input  logic           alu_ov,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [nIO-1:0] res_z,
  output logic           res_ov,
  output logic           res_err,
  output logic [7:0]     ov_count
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_t           state;
  state_t           state_next;
  logic             accept;
  logic             push;
  logic [nIO-1:0]   last_z;
  logic [CW-1:0]    fifo_count;
  logic [RES_W-1:0] push_word;
  logic [RES_W-1:0] head_word;
  logic             op_legal;
  logic             ov_bit;

  // Command acceptance and sequencing; a slot is reserved by requiring free space in IDLE.
  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    push       = 1'b0;
    case (state)
      ST_IDLE: begin
        cmd_ready = !rst && (fifo_count < CW'(DEPTH));
        if (cmd_valid && cmd_ready) state_next = ST_EXEC;
      end
      ST_EXEC: begin
        push       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign accept = cmd_valid && cmd_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Operand/opcode registers driving the ALU; chained commands reuse the last result as A.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a  <= '0;
      alu_b  <= '0;
      alu_op <= '0;
    end else if (accept) begin
      alu_a  <= cmd_chain ? last_z : cmd_a;
      alu_b  <= cmd_b;
      alu_op <= cmd_op;
    end
  end

  // Build the result word; overflow is only meaningful for add/sub, illegal ops report err.
  always_comb begin
    push_word = '0;
    op_legal  = op_is_legal(alu_op);
    ov_bit    = op_legal && ((alu_op == OP_ADD) || (alu_op == OP_SUB)) && (alu_ov == 1'b1);
    if (op_legal) push_word[Z_LSB +: nIO] = alu_z;
    push_word[OV_BIT]  = ov_bit;
    push_word[ERR_BIT] = !op_legal;
  end

  // Chain source and saturating overflow counter, both updated on every push.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_z   <= '0;
      ov_count <= '0;
    end else if (push) begin
      last_z <= push_word[Z_LSB +: nIO];
      if (push_word[OV_BIT] && (ov_count != 8'hFF)) ov_count <= ov_count + 8'd1;
    end
  end

  alu_result_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (RES_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_word),
    .pop       (res_ready),
    .valid     (res_valid),
    .head      (head_word),
    .count     (fifo_count)
  );

  assign res_z   = head_word[Z_LSB +: nIO];
  assign res_ov  = head_word[OV_BIT];
  assign res_err = head_word[ERR_BIT];

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - scoreboard testbench for alu_sequencer with a behavioural ALU
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic       cmd_chain;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [2:0] alu_op;
  logic [7:0] alu_z;
  logic       alu_ov;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_z;
  logic       res_ov;
  logic       res_err;
  logic [7:0] ov_count;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [9:0] exp_q[$];
  int         m_last     = 0;
  int         m_ov_count = 0;
  bit         rand_ready = 1'b0;

  alu_sequencer #(.nIO(8), .nOP(3), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_chain (cmd_chain),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_z     (alu_z),
    .alu_ov    (alu_ov),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_z     (res_z),
    .res_ov    (res_ov),
    .res_err   (res_err),
    .ov_count  (ov_count)
  );

  always #5 clk = ~clk;

  // External combinational ALU; ov is deliberately junk (1) for ops that do not define it.
  logic [7:0] sum;
  logic [7:0] dif;
  assign sum = alu_a + alu_b;
  assign dif = alu_a - alu_b;
  always_comb begin
    alu_z  = 8'h5A;
    alu_ov = 1'b1;
    case (alu_op)
      3'd0: begin alu_z = sum; alu_ov = (alu_a[7] == alu_b[7]) && (sum[7] != alu_a[7]); end
      3'd1: begin alu_z = dif; alu_ov = (alu_a[7] != alu_b[7]) && (dif[7] != alu_a[7]); end
      3'd2: alu_z = ($signed(alu_a) > $signed(alu_b)) ? alu_a : alu_b;
      3'd3: alu_z = ($signed(alu_a) < $signed(alu_b)) ? alu_a : alu_b;
      3'd4: alu_z = alu_a <<< 2;
      3'd5: alu_z = 8'($signed(alu_b) >>> 3);
      default: alu_z = 8'hA5;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result from plain integer arithmetic: {err, ov, z}.
  function automatic logic [9:0] ref_result(input int a, input int b, input int op);
    int r;
    logic ov;
    logic err;
    logic [7:0] z;
    r = 0; ov = 1'b0; err = 1'b0;
    case (op)
      0: begin r = a + b; ov = (r > 127) || (r < -128); end
      1: begin r = a - b; ov = (r > 127) || (r < -128); end
      2: r = (a > b) ? a : b;
      3: r = (a < b) ? a : b;
      4: r = a * 4;
      5: r = b >>> 3;
      default: err = 1'b1;
    endcase
    z = err ? 8'h00 : r[7:0];
    return {err, ov, z};
  endfunction

  task automatic model_accept(input int a, input int b, input int op, input bit chain);
    logic [9:0]        e;
    logic signed [7:0] zs;
    e  = ref_result(chain ? m_last : a, b, op);
    zs = e[7:0];
    m_last = zs;
    if (e[8] && m_ov_count < 255) m_ov_count++;
    exp_q.push_back(e);
  endtask

  task automatic drive(input int a, input int b, input int op, input bit chain);
    logic [31:0] av;
    logic [31:0] bv;
    logic [31:0] ov;
    av = a; bv = b; ov = op;
    cmd_a     = av[7:0];
    cmd_b     = bv[7:0];
    cmd_op    = ov[2:0];
    cmd_chain = chain;
    cmd_valid = 1'b1;
  endtask

  task automatic wait_accept(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
    end
    #1 cmd_valid = 1'b0;
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic issue(input int a, input int b, input int op, input bit chain);
    bit ok;
    drive(a, b, op, chain);
    wait_accept(100, ok);
    if (ok) model_accept(a, b, op, chain);
  endtask

  task automatic drain();
    bit done;
    rand_ready = 1'b0;
    res_ready  = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !res_valid) done = 1'b1;
    end
    check("drain_pending", exp_q.size(), 32'd0);
    @(posedge clk); #1;
  endtask

  // Monitor: every pop the DUT performs is compared against the scoreboard head.
  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", {res_err, res_ov, res_z}, 32'h3FF);
      end else begin
        check("result", {22'd0, res_err, res_ov, res_z}, {22'd0, exp_q.pop_front()});
      end
    end
  end

  // Random consumer backpressure during the random phase.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) res_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    bit saw_ready;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0;
    cmd_chain = 1'b0; res_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_cmd_ready", cmd_ready, 0);
    check("reset_res", {res_valid, res_ov, res_err, res_z}, 0);
    check("reset_alu", {alu_a, alu_b, alu_op}, 0);
    check("reset_ov_count", ov_count, 0);
    @(posedge clk); #1 rst = 1'b0;

    // Directed operations
    issue(100, 50, 0, 0);
    drain();
    check("ov_count_first", ov_count, 1);
    issue(-128, 1, 1, 0);
    issue(-3, 5, 2, 0);
    issue(-3, 5, 3, 0);
    issue(8'h41, 0, 4, 0);
    issue(0, -128, 5, 0);
    issue(7, 9, 6, 0);
    issue(0, 5, 0, 1);
    issue(3, 4, 0, 0);
    issue(0, 10, 0, 1);
    issue(0, 20, 1, 1);
    drain();
    check("ov_count_directed", ov_count, m_ov_count);

    // Backpressure: four accepted, fifth stalls until the consumer drains
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) issue(10 * i, i + 1, 0, 0);
    drive(1, 2, 1, 0);
    saw_ready = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (cmd_ready) saw_ready = 1'b1;
    end
    check("bp_cmd_ready_low", saw_ready, 0);
    check("bp_res_valid", res_valid, 1);
    @(posedge clk); #1 res_ready = 1'b1;
    wait_accept(100, ok);
    if (ok) model_accept(1, 2, 1, 0);
    drain();

    // Reset during EXEC with two entries queued
    res_ready = 1'b0;
    issue(100, 100, 0, 0);
    issue(-100, 100, 1, 0);
    drive(1, 1, 0, 0);
    wait_accept(100, ok);
    rst = 1'b1;
    exp_q.delete();
    m_last = 0;
    m_ov_count = 0;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_res_valid", res_valid, 0);
    check("rst_mid_ov_count", ov_count, 0);
    check("rst_mid_alu", {alu_a, alu_b, alu_op}, 0);
    @(posedge clk); #1 rst = 1'b0;
    res_ready = 1'b1;
    issue(0, 9, 0, 1);
    drain();

    // Random commands with random consumer backpressure
    rand_ready = 1'b1;
    for (int i = 0; i < 80; i++) begin
      issue($urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128,
            $urandom_range(0, 7), ($urandom_range(0, 3) == 0));
    end
    drain();
    check("ov_count_random", ov_count, m_ov_count);

    // Overflow counter saturation
    for (int i = 0; i < 260; i++) issue(100, 100, 0, 0);
    drain();
    check("ov_count_saturated", ov_count, 255);
    check("ov_count_model", ov_count, m_ov_count);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
